// File: rtl/dac_spi_frame_gen_if.sv
// ---------------------------------------------------------------------------
// dac_spi_frame_gen_if
// Bundles the frame request inputs and the SPI frame timing outputs of
// dac_spi_frame_gen.
//   master : drives start/key_state/dac_cmd/dac_code, observes frame outputs
//   slave  : the frame generator itself
// Signals:
//   start      frame request, sampled on clk
//   key_state  global run enable (low = abort and hold idle)
//   dac_cmd    4-bit command/address nibble -> data_sdi[15:12]
//   dac_code   12-bit DAC code              -> data_sdi[11:0]
//   data_sdi   latched frame word, MSB first on the wire
//   en_dac     1-cycle pulse when a new frame word is loaded
//   cs         chip select, active low
//   sck        SPI clock, idle low
//   cnt_sck    index of the bit on the wire (0..15), 16 = frame complete
//   busy       frame in progress
//   done       1-cycle pulse at end of frame (after the cs-high gap)
// ---------------------------------------------------------------------------
interface dac_spi_frame_gen_if;
  logic        start;
  logic        key_state;
  logic [3:0]  dac_cmd;
  logic [11:0] dac_code;
  logic [15:0] data_sdi;
  logic        en_dac;
  logic        cs;
  logic        sck;
  logic [4:0]  cnt_sck;
  logic        busy;
  logic        done;

  modport master (
    output start, key_state, dac_cmd, dac_code,
    input  data_sdi, en_dac, cs, sck, cnt_sck, busy, done
  );

  modport slave (
    input  start, key_state, dac_cmd, dac_code,
    output data_sdi, en_dac, cs, sck, cnt_sck, busy, done
  );
endinterface

// File: rtl/dac_spi_frame_gen.sv
// ---------------------------------------------------------------------------
// dac_spi_frame_gen
// SPI frame timing generator feeding the 16-bit DAC serializer. One
// {cmd,code} word is latched per accepted start request; the block then
// produces en_dac, a 16-bit cs-low window with sck (idle low, data sampled
// on the rising edge), the bit index cnt_sck and a cs-high gap long enough
// for the downstream ldac pulse before signalling done.
// Parameters:
//   SCK_DIV    sck half-period in clk cycles (>=1)
//   FRAME_GAP  clk cycles cs stays high after the last bit, done on the last
//              of them (>=2; >=10 leaves room for ldac)
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    dac_spi_frame_gen_if.slave (request inputs, frame outputs)
// ---------------------------------------------------------------------------
module dac_spi_frame_gen #(
  parameter int SCK_DIV   = 2,
  parameter int FRAME_GAP = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  dac_spi_frame_gen_if.slave  bus
);

  localparam int HC_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int GC_W = (FRAME_GAP > 2) ? $clog2(FRAME_GAP) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCK_DIV - 1);
  // done is raised on the edge that ends the gap, so the counter stops one
  // short of FRAME_GAP-1 (counting starts at 0 on the cs-high edge).
  localparam logic [GC_W-1:0] GC_DONE = GC_W'(FRAME_GAP - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]      r_state;
  logic [15:0]     r_word;
  logic [15:0]     r_data_sdi;
  logic            r_en_dac;
  logic            r_cs;
  logic            r_sck;
  logic [4:0]      r_cnt_sck;
  logic            r_busy;
  logic            r_done;
  logic [HC_W-1:0] r_hc;
  logic [GC_W-1:0] r_gc;

  logic            w_hc_wrap;

  assign w_hc_wrap = (r_hc == HC_LAST);

  // Frame sequencer: request latch, sck/cs generation, gap timing, abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_word     <= 16'h0000;
      r_data_sdi <= 16'h0000;
      r_en_dac   <= 1'b0;
      r_cs       <= 1'b1;
      r_sck      <= 1'b0;
      r_cnt_sck  <= 5'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hc       <= '0;
      r_gc       <= '0;
    end else if (!bus.key_state) begin
      // Abort: back to idle at once, no done; the last word stays visible.
      r_state   <= S_IDLE;
      r_en_dac  <= 1'b0;
      r_cs      <= 1'b1;
      r_sck     <= 1'b0;
      r_cnt_sck <= 5'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hc      <= '0;
      r_gc      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_en_dac  <= 1'b0;
          r_cs      <= 1'b1;
          r_sck     <= 1'b0;
          r_cnt_sck <= 5'd0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_hc      <= '0;
          r_gc      <= '0;
          if (bus.start) begin
            r_word  <= {bus.dac_cmd, bus.dac_code};
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_data_sdi <= r_word;
          r_en_dac   <= 1'b1;
          r_busy     <= 1'b1;
          r_hc       <= '0;
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          r_en_dac <= 1'b0;
          if (r_cs) begin
            // First SHIFT cycle: open the frame, bit 0 starts its low phase.
            r_cs      <= 1'b0;
            r_hc      <= '0;
            r_cnt_sck <= 5'd0;
          end else if (w_hc_wrap) begin
            r_hc  <= '0;
            r_sck <= ~r_sck;
            if (r_sck) begin
              // Falling edge: advance to the next bit; after bit 15 close cs.
              r_cnt_sck <= r_cnt_sck + 5'd1;
              if (r_cnt_sck == 5'd15) begin
                r_cs    <= 1'b1;
                r_gc    <= '0;
                r_state <= S_GAP;
              end
            end
          end else begin
            r_hc <= r_hc + HC_W'(1);
          end
        end
        S_GAP: begin
          if (r_gc == GC_DONE) begin
            // busy and cnt_sck=16 stay up through the done cycle; idle clears them.
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_gc <= r_gc + GC_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_en_dac  <= 1'b0;
          r_cs      <= 1'b1;
          r_sck     <= 1'b0;
          r_cnt_sck <= 5'd0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_hc      <= '0;
          r_gc      <= '0;
        end
      endcase
    end
  end

  assign bus.data_sdi = r_data_sdi;
  assign bus.en_dac   = r_en_dac;
  assign bus.cs       = r_cs;
  assign bus.sck      = r_sck;
  assign bus.cnt_sck  = r_cnt_sck;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_dac_spi_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_dac_spi_frame_gen
// Two generators share the same request inputs: dut_a (SCK_DIV=2) and
// dut_b (SCK_DIV=1), both with FRAME_GAP=10. Expected waveforms come from
// model(), which states each output as a closed-form function of the clock
// offset k from the edge that accepted start.
// ---------------------------------------------------------------------------
module tb_dac_spi_frame_gen;

  localparam int GAP = 10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        key   = 1'b1;
  logic [3:0]  cmd   = 4'h0;
  logic [11:0] code  = 12'h000;

  int n_checks = 0;
  int n_fail   = 0;

  dac_spi_frame_gen_if ifa ();
  dac_spi_frame_gen_if ifb ();

  assign ifa.start     = start;
  assign ifa.key_state = key;
  assign ifa.dac_cmd   = cmd;
  assign ifa.dac_code  = code;
  assign ifb.start     = start;
  assign ifb.key_state = key;
  assign ifb.dac_cmd   = cmd;
  assign ifb.dac_code  = code;

  dac_spi_frame_gen #(.SCK_DIV(2), .FRAME_GAP(GAP)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  dac_spi_frame_gen #(.SCK_DIV(1), .FRAME_GAP(GAP)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;

  // Observed outputs: {data_sdi[25:10], en_dac[9], cs[8], sck[7], cnt_sck[6:2], busy[1], done[0]}
  function automatic logic [25:0] obs(input int s);
    if (s == 1)
      return {ifb.data_sdi, ifb.en_dac, ifb.cs, ifb.sck, ifb.cnt_sck, ifb.busy, ifb.done};
    else
      return {ifa.data_sdi, ifa.en_dac, ifa.cs, ifa.sck, ifa.cnt_sck, ifa.busy, ifa.done};
  endfunction

  // Expected control outputs k clocks after the accepting edge (k=0 is that edge).
  function automatic logic [9:0] model(input int k, input int s);
    int cs_end, done_k;
    logic en, cs, sck, busy, done;
    logic [4:0] cnt;
    cs_end = 1 + 32 * s;
    done_k = cs_end + GAP;
    en   = (k == 1);
    busy = (k >= 1) && (k <= done_k);
    done = (k == done_k);
    cs   = 1'b1;
    sck  = 1'b0;
    cnt  = 5'd0;
    if (k >= 2 && k <= cs_end) begin
      cs  = 1'b0;
      sck = 1'(((k - 2) / s) % 2);
      cnt = 5'((k - 2) / (2 * s));
    end else if (k > cs_end && k <= done_k) begin
      cnt = 5'd16;
    end
    return {en, cs, sck, cnt, busy, done};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [25:0] rv;
    rv = {16'h0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    @(negedge clk);
    for (int s = 1; s <= 2; s++) begin
      n_checks++;
      if (obs(s) !== rv) begin
        n_fail++;
        $display("FAIL reset_state div=%0d got=%h exp=%h", s, obs(s), rv);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs(2) !== rv) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs(2), rv);
      end
    end
  endtask

  // One complete frame on the selected generator; request inputs scrambled after acceptance.
  task automatic test_frame(input int s, input logic [3:0] c, input logic [11:0] d, input string tag);
    logic [15:0] w, bits, dat;
    logic [25:0] o;
    logic [4:0]  cnt;
    logic        prev_sck;
    int          rises, last;
    w = {c, d};
    bits = 16'h0000;
    rises = 0;
    prev_sck = 1'b0;
    last = 2 + 32 * s + GAP;
    cmd = c;
    code = d;
    start = 1'b1;
    for (int k = 0; k <= last; k++) begin
      step();
      if (k == 0) start = 1'b0;
      cmd  = 4'($urandom);
      code = 12'($urandom);
      o = obs(s);
      dat = o[25:10];
      cnt = o[6:2];
      n_checks++;
      if (o[9:0] !== model(k, s)) begin
        n_fail++;
        $display("FAIL %s ctl k=%0d got=%b exp=%b", tag, k, o[9:0], model(k, s));
      end
      if (k >= 1) begin
        n_checks++;
        if (dat !== w) begin
          n_fail++;
          $display("FAIL %s data_sdi k=%0d got=%h exp=%h", tag, k, dat, w);
        end
      end
      if (o[7] === 1'b1 && prev_sck === 1'b0 && cnt < 5'd16) begin
        rises++;
        bits = {bits[14:0], dat[15 - int'(cnt)]};
      end
      prev_sck = o[7];
    end
    n_checks++;
    if (bits !== w || rises != 16) begin
      n_fail++;
      $display("FAIL %s wire_bits got=%h rises=%0d exp=%h rises=16", tag, bits, rises, w);
    end
  endtask

  task automatic test_back_to_back();
    int period, k, en_cnt, done_cnt;
    logic [15:0] cur, pend;
    logic [25:0] o;
    period = 2 + 32 * 2 + GAP;
    en_cnt = 0;
    done_cnt = 0;
    cur = 16'h0000;
    pend = 16'($urandom);
    cmd = pend[15:12];
    code = pend[11:0];
    start = 1'b1;
    for (int c = 0; c <= 3 * period; c++) begin
      step();
      k = c % period;
      if (c == 3 * period - 1) start = 1'b0;
      if (k == 0 && c < 3 * period) begin
        cur = pend;
        pend = 16'($urandom);
        cmd = pend[15:12];
        code = pend[11:0];
      end
      o = obs(2);
      if (o[9] === 1'b1) en_cnt++;
      if (o[0] === 1'b1) done_cnt++;
      n_checks++;
      if (o[9:0] !== model(k, 2)) begin
        n_fail++;
        $display("FAIL b2b ctl c=%0d got=%b exp=%b", c, o[9:0], model(k, 2));
      end
      if (k >= 1) begin
        n_checks++;
        if (o[25:10] !== cur) begin
          n_fail++;
          $display("FAIL b2b data_sdi c=%0d got=%h exp=%h", c, o[25:10], cur);
        end
      end
    end
    n_checks++;
    if (en_cnt != 3 || done_cnt != 3) begin
      n_fail++;
      $display("FAIL b2b pulses en_dac=%0d done=%0d exp 3/3", en_cnt, done_cnt);
    end
  endtask

  task automatic test_start_during_shift();
    logic [15:0] w;
    logic [25:0] o;
    int jk, done_k;
    w = 16'($urandom);
    done_k = 1 + 32 * 2 + GAP;
    jk = int'($urandom_range(60, 4));
    cmd = w[15:12];
    code = w[11:0];
    start = 1'b1;
    for (int k = 0; k <= done_k + 2; k++) begin
      step();
      start = (k == jk) || (k == done_k - 1);
      cmd  = ~w[15:12];
      code = ~w[11:0];
      o = obs(2);
      n_checks++;
      if (o[9:0] !== model(k, 2)) begin
        n_fail++;
        $display("FAIL busy_start ctl k=%0d got=%b exp=%b", k, o[9:0], model(k, 2));
      end
      if (k >= 1) begin
        n_checks++;
        if (o[25:10] !== w) begin
          n_fail++;
          $display("FAIL busy_start data_sdi k=%0d got=%h exp=%h", k, o[25:10], w);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_key_abort();
    logic [15:0] w;
    logic [25:0] o, exp_abort;
    int drop;
    w = 16'($urandom);
    drop = 30 + int'($urandom_range(3, 0));
    cmd = w[15:12];
    code = w[11:0];
    start = 1'b1;
    for (int k = 0; k <= drop; k++) begin
      step();
      if (k == 0) start = 1'b0;
      o = obs(2);
      n_checks++;
      if (o[9:0] !== model(k, 2)) begin
        n_fail++;
        $display("FAIL abort_pre ctl k=%0d got=%b exp=%b", k, o[9:0], model(k, 2));
      end
    end
    n_checks++;
    if (obs(2) !== {w, 1'b0, 1'b0, obs(2)[7], 5'd7, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_at_cnt7 got=%h", obs(2));
    end
    key = 1'b0;
    start = 1'b1;
    exp_abort = {w, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (obs(2) !== exp_abort) begin
        n_fail++;
        $display("FAIL abort_idle cyc=%0d got=%h exp=%h", i, obs(2), exp_abort);
      end
    end
    start = 1'b0;
    key = 1'b1;
    step();
    n_checks++;
    if (obs(2) !== exp_abort) begin
      n_fail++;
      $display("FAIL abort_resume_idle got=%h exp=%h", obs(2), exp_abort);
    end
    test_frame(2, 4'($urandom), 12'($urandom), "after_abort");
  endtask

  task automatic test_async_reset();
    logic [25:0] rv;
    rv = {16'h0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    cmd = 4'($urandom);
    code = 12'($urandom);
    start = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      if (k == 0) start = 1'b0;
      n_checks++;
      if (obs(2)[9:0] !== model(k, 2)) begin
        n_fail++;
        $display("FAIL arst_pre ctl k=%0d got=%b exp=%b", k, obs(2)[9:0], model(k, 2));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int s = 1; s <= 2; s++) begin
      n_checks++;
      if (obs(s) !== rv) begin
        n_fail++;
        $display("FAIL arst_immediate div=%0d got=%h exp=%h", s, obs(s), rv);
      end
    end
    @(negedge clk);
    n_checks++;
    if (obs(2) !== rv) begin
      n_fail++;
      $display("FAIL arst_hold got=%h exp=%h", obs(2), rv);
    end
    rst_n = 1'b1;
    step();
    step();
    test_frame(2, 4'h3, 12'hA5C, "after_arst");
  endtask

  task automatic test_sck_div1();
    for (int i = 0; i < 60; i++) step();
    n_checks++;
    if (obs(1)[9:0] !== model(0, 1)) begin
      n_fail++;
      $display("FAIL div1_idle got=%b exp=%b", obs(1)[9:0], model(0, 1));
    end
    test_frame(1, 4'h0, 12'hFFF, "div1");
    test_frame(1, 4'($urandom), 12'($urandom), "div1_rand");
  endtask

  initial begin
    test_reset();
    test_frame(2, 4'h3, 12'hA5C, "scn1");
    for (int i = 0; i < 3; i++) test_frame(2, 4'($urandom), 12'($urandom), "rand");
    test_back_to_back();
    test_start_during_shift();
    test_key_abort();
    test_async_reset();
    test_sck_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
